// File: rtl/barcode_pkg.sv
// Shared types and defaults for the station barcode receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package barcode_pkg;

  localparam int BC_CNT_W      = 22;
  localparam int BC_ID_W       = 8;
  localparam int BC_MIN_PERIOD = 16;

  // Only IDs whose two upper bits match this prefix are accepted.
  localparam logic [1:0] VALID_PREFIX = 2'b00;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_FALL = 3'd2,
    WAIT_SMPL = 3'd3,
    CHECK     = 3'd4
  } bc_state_t;

  function automatic logic prefix_ok(input logic [1:0] top_bits);
    return top_bits == VALID_PREFIX;
  endfunction

endpackage

// File: rtl/barcode_reader_if.sv
// Barcode line / station-ID bundle between the BC pin side and the cmd FSM.
// Latency: n/a (wires only).
// Backpressure: none; ID_vld stays up until clr_ID_vld consumes it.
// Signals: BC (raw line, idle high), clr_ID_vld (clear pulse), ID, ID_vld, busy,
// and bc_err when BARCODE_TIMEOUT_EN is defined.
interface barcode_reader_if #(
  parameter int ID_W = 8
);
  logic            BC;
  logic            clr_ID_vld;
  logic [ID_W-1:0] ID;
  logic            ID_vld;
  logic            busy;
`ifdef BARCODE_TIMEOUT_EN
  logic            bc_err;

  modport master (output BC, output clr_ID_vld,
                  input ID, input ID_vld, input busy, input bc_err);
  modport slave  (input BC, input clr_ID_vld,
                  output ID, output ID_vld, output busy, output bc_err);
`else
  modport master (output BC, output clr_ID_vld,
                  input ID, input ID_vld, input busy);
  modport slave  (input BC, input clr_ID_vld,
                  output ID, output ID_vld, output busy);
`endif
endinterface

// File: rtl/bc_sync_edge.sv
// Two-flop synchronizer for the asynchronous BC line plus edge detection.
// Latency: bc_s_o lags bc_i by 2 clk; fall_o/rise_o are valid in the cycle bc_s_o changes.
// Backpressure: none.
// Ports: clk, rst (async high), bc_i (raw line), bc_s_o (synced level),
// fall_o / rise_o (one-cycle edge strobes on the synced level).
module bc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic bc_i,
  output logic bc_s_o,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // All flops reset to the idle-high line level so no spurious edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bc_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign bc_s_o = sync2_q;
  assign fall_o = prev_q & ~sync2_q;
  assign rise_o = ~prev_q & sync2_q;

endmodule

// File: rtl/barcode_reader.sv
// Station barcode decoder: measures start-bit low time T, samples 8 bits MSB-first T clk after each fall.
// Latency: ID/ID_vld update 1 clk after the 8th sample (edge detect adds 3 clk from the pin).
// Backpressure: none; a new accepted frame overwrites ID even if ID_vld is still set.
// Ports: clk, rst (async high), bus (barcode_reader_if.slave: BC, clr_ID_vld, ID, ID_vld, busy).
// Optional BARCODE_TIMEOUT_EN: WAIT_FALL watchdog (> 4*T aborts the frame) and sticky bus.bc_err.
module barcode_reader
  import barcode_pkg::*;
#(
  parameter int CNT_W      = BC_CNT_W,
  parameter int ID_W       = BC_ID_W,
  parameter int MIN_PERIOD = BC_MIN_PERIOD
) (
  input logic              clk,
  input logic              rst,
  barcode_reader_if.slave  bus
);

  localparam int BIT_W = $clog2(ID_W + 1);

  logic bc_s;
  logic fall;
  logic rise;

  bc_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .bc_i   (bus.BC),
    .bc_s_o (bc_s),
    .fall_o (fall),
    .rise_o (rise)
  );

  bc_state_t         state_q,      state_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  t_q,          t_d;
  logic [CNT_W-1:0]  tmr_q,        tmr_d;
  logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [ID_W-1:0]   shift_q,      shift_d;
  logic [ID_W-1:0]   id_q,         id_d;
  logic              id_vld_q,     id_vld_d;
  logic              vld_set;

`ifdef BARCODE_TIMEOUT_EN
  // Two extra bits so 4*T never overflows the watchdog compare.
  logic [CNT_W+1:0]  wd_q,         wd_d;
  logic              err_q,        err_d;
  logic              abort;
`endif

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    t_d          = t_q;
    tmr_d        = tmr_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    id_d         = id_q;
    vld_set      = 1'b0;
`ifdef BARCODE_TIMEOUT_EN
    abort        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (fall) begin
          period_cnt_d = '0;
          state_d      = START;
        end
      end

      START: begin
        if (rise) begin
          if (period_cnt_q >= CNT_W'(MIN_PERIOD)) begin
            t_d       = period_cnt_q;
            bit_cnt_d = '0;
            state_d   = WAIT_FALL;
          end else begin
            // Too short to be a start bit: treat as line noise.
            state_d = IDLE;
          end
        end else if (period_cnt_q == '1) begin
          // Line stuck low longer than the counter can measure.
          state_d = IDLE;
        end else if (!bc_s) begin
          period_cnt_d = period_cnt_q + CNT_W'(1);
        end
      end

      WAIT_FALL: begin
        if (fall) begin
          tmr_d   = '0;
          state_d = WAIT_SMPL;
        end
`ifdef BARCODE_TIMEOUT_EN
        else if (wd_q > {t_q, 2'b00}) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
`endif
      end

      WAIT_SMPL: begin
        // Falls before the sample point are deliberately ignored (no resync).
        if (tmr_q == t_q - CNT_W'(1)) begin
          shift_d   = {shift_q[ID_W-2:0], bc_s};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          state_d   = (bit_cnt_d == BIT_W'(ID_W)) ? CHECK : WAIT_FALL;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end

      CHECK: begin
        if (prefix_ok(shift_q[ID_W-1:ID_W-2])) begin
          id_d    = shift_q;
          vld_set = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A frame acceptance in the same cycle as a clear must not be lost.
    if (vld_set)             id_vld_d = 1'b1;
    else if (bus.clr_ID_vld) id_vld_d = 1'b0;
    else                     id_vld_d = id_vld_q;

`ifdef BARCODE_TIMEOUT_EN
    wd_d = (state_q == WAIT_FALL) ? wd_q + (CNT_W+2)'(1) : '0;
    if (abort)               err_d = 1'b1;
    else if (bus.clr_ID_vld) err_d = 1'b0;
    else                     err_d = err_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      t_q          <= '0;
      tmr_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      id_q         <= '0;
      id_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      t_q          <= t_d;
      tmr_q        <= tmr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      id_q         <= id_d;
      id_vld_q     <= id_vld_d;
    end
  end

`ifdef BARCODE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.bc_err = err_q;
`endif

  assign bus.ID     = id_q;
  assign bus.ID_vld = id_vld_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_barcode_reader.sv
// Randomized + directed bench for barcode_reader with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_barcode_reader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  barcode_reader_if #(.ID_W(8)) bus ();

  barcode_reader #(
    .CNT_W      (22),
    .ID_W       (8),
    .MIN_PERIOD (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] id;
    logic       vld;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] m_id   = 8'h00;
  logic       m_vld  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference behaviour: an ID is adopted only if its top two bits are zero.
  function automatic void model_frame(input logic [7:0] v);
    if (v[7:6] == 2'b00) begin
      m_id  = v;
      m_vld = 1'b1;
    end
  endfunction

  // Drive BC to v for n clk; always called on a negedge and returns on one.
  task automatic hold(input logic v, input int n);
    bus.BC = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int p);
    if (b) begin
      hold(1'b0, p / 2);
      hold(1'b1, p + p / 2);
    end else begin
      hold(1'b0, p + p / 2);
      hold(1'b1, p / 2);
    end
  endtask

  // Start bit low p, high p, then the first nbits of v MSB-first.
  task automatic send_bits(input logic [7:0] v, input int p, input int nbits);
    hold(1'b0, p);
    hold(1'b1, p);
    for (int i = 7; i > 7 - nbits; i--) send_bit(v[i], p);
  endtask

  task automatic send_frame(input logic [7:0] v, input int p);
    model_frame(v);
    exp_q.push_back('{id: m_id, vld: m_vld});
    send_bits(v, p, 8);
    hold(1'b1, 8);
  endtask

  // Hold clr_ID_vld high across the last bit, dropping it once the frame ends,
  // so the clear overlaps the acceptance cycle.
  task automatic send_frame_clr_last(input logic [7:0] v, input int p);
    m_vld = 1'b0;
    model_frame(v);
    exp_q.push_back('{id: m_id, vld: m_vld});
    send_bits(v, p, 7);
    bus.clr_ID_vld = 1'b1;
    fork
      send_bit(v[0], p);
      begin
        for (int k = 0; k < 4 * p + 100; k++) begin
          @(negedge clk);
          if (!bus.busy) break;
        end
        bus.clr_ID_vld = 1'b0;
      end
    join
    hold(1'b1, 8);
  endtask

  task automatic clr_pulse();
    bus.clr_ID_vld = 1'b1;
    @(negedge clk);
    bus.clr_ID_vld = 1'b0;
    m_vld = 1'b0;
    check("clr_vld", 32'(bus.ID_vld), 32'(1'b0));
    check("clr_id_kept", 32'(bus.ID), 32'(m_id));
  endtask

  // Monitor: every end of a busy episode pops one expectation.
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !bus.busy) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame_end: actual ID=%0h vld=%0b required no event",
                     bus.ID, bus.ID_vld);
          end else begin
            e = exp_q.pop_front();
            check("sb_id", 32'(bus.ID), 32'(e.id));
            check("sb_vld", 32'(bus.ID_vld), 32'(e.vld));
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    int         p;
    logic [7:0] id;

    rst            = 1'b1;
    bus.BC         = 1'b1;
    bus.clr_ID_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_id", 32'(bus.ID), 32'h0);
    check("rst_vld", 32'(bus.ID_vld), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
`ifdef BARCODE_TIMEOUT_EN
    check("rst_err", 32'(bus.bc_err), 32'h0);
`endif
    rst = 1'b0;
    hold(1'b1, 5);

    // Rejected prefix from a clean state, then a valid ID.
    send_frame(8'hC5, 22'h20a);
    send_frame(8'h25, 22'h20a);
    check("busy_idle", 32'(bus.busy), 32'h0);

    // Clear pulse, then clear colliding with acceptance.
    clr_pulse();
    send_frame_clr_last(8'h12, 22'h100);
    repeat (3) @(negedge clk);
    check("collision_vld_kept", 32'(bus.ID_vld), 32'h1);

    // Short low glitch must not start a frame.
    exp_q.push_back('{id: m_id, vld: m_vld});
    hold(1'b0, 5);
    hold(1'b1, 20);
    send_frame(8'h3F, 22'h100);

    // Back-to-back without clearing.
    send_frame(8'h01, 22'h100);
    send_frame(8'h3E, 22'h100);

    // Reset after the 4th bit of a frame.
    send_bits(8'h15, 22'h100, 4);
    #2 rst = 1'b1;
    #1;
    check("midrst_id", 32'(bus.ID), 32'h0);
    check("midrst_vld", 32'(bus.ID_vld), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    m_id  = 8'h00;
    m_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 5);
    send_frame(8'h2A, 22'h100);

`ifdef BARCODE_TIMEOUT_EN
    // Truncated frame: start plus 3 bits, then the line stays high.
    exp_q.push_back('{id: m_id, vld: m_vld});
    send_bits(8'h0A, 64, 3);
    bus.BC = 1'b1;
    for (int k = 0; k < 4 * 64 + 200; k++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    check("to_busy", 32'(bus.busy), 32'h0);
    check("to_err", 32'(bus.bc_err), 32'h1);
    check("to_vld", 32'(bus.ID_vld), 32'(m_vld));
    clr_pulse();
    check("to_err_clr", 32'(bus.bc_err), 32'h0);
`endif

    // Randomized frames with random periods, gaps and clears.
    for (int n = 0; n < 8; n++) begin
      p  = int'($urandom_range(20, 60));
      id = 8'($urandom);
      if ($urandom_range(0, 1) == 1) id[7:6] = 2'b00;
      send_frame(id, p);
      hold(1'b1, int'($urandom_range(1, 30)));
      if ($urandom_range(0, 2) == 0) clr_pulse();
    end

    repeat (10) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
